// File: rtl/dma_rd_port.sv
// DMA read port: fetches one burst of 16-bit elements from a 32-bit memory
// read FIFO and streams them to the engine low half first.
module dma_rd_port #(
    parameter int unsigned BURST_LEN = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reads_en,
    input  logic [29:0] addr,
    output logic [15:0] ob_data,
    output logic        ob_we,
    output logic        busy,
    output logic        done,
    output logic        cmd_en,
    output logic [2:0]  cmd_instr,
    output logic [5:0]  cmd_bl,
    output logic [29:0] cmd_byte_addr,
    input  logic        cmd_full,
    output logic        rd_en,
    input  logic [31:0] rd_data,
    input  logic        rd_empty
);

    localparam int unsigned HALF = BURST_LEN / 2;
    localparam int unsigned CW   = 6;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        FETCH,
        EMIT_HI,
        DONE
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic            odd_q;
    logic [CW-1:0]   word_cnt;
    logic [31:0]     hold;
    logic            accept;
    logic            first_word;
    logic            last_word;
    logic            emit_lo;
    logic            emit_hi;
    logic            unused_addr;

    // Element address bit 29 falls off the top of the 30-bit byte address.
    assign unused_addr = addr[29];
    assign cmd_instr   = 3'b001;

    assign first_word = (word_cnt == CW'(0));
    assign last_word  = (word_cnt == CW'(cmd_bl + CW'(1)));

    // Next-state decode plus the combinational memory strobes.
    always_comb begin
        state_nx = state;
        cmd_en   = 1'b0;
        rd_en    = 1'b0;
        accept   = 1'b0;
        emit_lo  = 1'b0;
        emit_hi  = 1'b0;
        case (state)
            IDLE: begin
                if (reads_en) begin
                    accept   = 1'b1;
                    state_nx = CMD;
                end
            end
            CMD: begin
                if (!cmd_full) begin
                    cmd_en   = 1'b1;
                    state_nx = FETCH;
                end
            end
            FETCH: begin
                if (!rd_empty) begin
                    rd_en    = 1'b1;
                    emit_lo  = !(odd_q && first_word);
                    state_nx = EMIT_HI;
                end
            end
            EMIT_HI: begin
                emit_hi  = !(odd_q && last_word);
                state_nx = last_word ? DONE : FETCH;
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Burst context, word counter, hold register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy          <= 1'b0;
            done          <= 1'b0;
            ob_we         <= 1'b0;
            ob_data       <= '0;
            cmd_bl        <= '0;
            cmd_byte_addr <= '0;
            odd_q         <= 1'b0;
            word_cnt      <= '0;
            hold          <= '0;
        end else begin
            busy  <= (state_nx != IDLE);
            done  <= (state_nx == DONE);
            ob_we <= emit_lo | emit_hi;
            if (accept) begin
                odd_q         <= addr[0];
                cmd_byte_addr <= {addr[28:1], 2'b00};
                cmd_bl        <= addr[0] ? CW'(HALF) : CW'(HALF - 1);
                word_cnt      <= '0;
            end
            if (rd_en) begin
                hold     <= rd_data;
                word_cnt <= word_cnt + CW'(1);
            end
            if (emit_lo) begin
                ob_data <= rd_data[15:0];
            end else if (emit_hi) begin
                ob_data <= hold[31:16];
            end
        end
    end

endmodule

// File: tb/tb_dma_rd_port.sv
// Directed bench for dma_rd_port with a memory FIFO model and an element scoreboard.
module tb_dma_rd_port;

    localparam int unsigned BL = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        reads_en;
    logic [29:0] addr;
    logic [15:0] ob_data;
    logic        ob_we;
    logic        busy;
    logic        done;
    logic        cmd_en;
    logic [2:0]  cmd_instr;
    logic [5:0]  cmd_bl;
    logic [29:0] cmd_byte_addr;
    logic        cmd_full;
    logic        rd_en;
    logic [31:0] rd_data = 32'h0;
    logic        rd_empty = 1'b1;

    int n_checks = 0;
    int n_pass   = 0;
    int ob_cnt   = 0;
    int done_cnt = 0;
    int pop_cnt  = 0;
    int bad_pop  = 0;
    bit stall_rand = 1'b0;

    logic [15:0] exp_q[$];
    logic [31:0] mq[$];
    logic [35:0] cmd_log[$];

    dma_rd_port #(.BURST_LEN(BL)) dut (
        .clk(clk), .rst(rst), .reads_en(reads_en), .addr(addr),
        .ob_data(ob_data), .ob_we(ob_we), .busy(busy), .done(done),
        .cmd_en(cmd_en), .cmd_instr(cmd_instr), .cmd_bl(cmd_bl),
        .cmd_byte_addr(cmd_byte_addr), .cmd_full(cmd_full),
        .rd_en(rd_en), .rd_data(rd_data), .rd_empty(rd_empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Memory: each command yields words {2k+1, 2k}; optional random empty gaps.
    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
        end else begin
            if (rd_en) begin
                if (rd_empty || mq.size() == 0) bad_pop++;
                else begin
                    void'(mq.pop_front());
                    pop_cnt++;
                end
            end
            if (cmd_en) begin
                cmd_log.push_back({cmd_bl, cmd_byte_addr});
                for (int k = 0; k <= int'(cmd_bl); k++)
                    mq.push_back({16'(2 * k + 1), 16'(2 * k)});
            end
        end
        rd_empty <= (mq.size() == 0) || (stall_rand && ($urandom_range(0, 1) == 1));
        rd_data  <= (mq.size() != 0) ? mq[0] : 32'h0;
    end

    // Scoreboard: every ob_we pops one expected element.
    always @(negedge clk) begin
        logic [15:0] e;
        if (ob_we) begin
            ob_cnt++;
            if (exp_q.size() != 0) e = exp_q.pop_front();
            else e = 'x;
            check("ob_data", 36'(ob_data), 36'(e));
        end
        if (done) done_cnt++;
    end

    task automatic push_exp(input logic [29:0] a);
        for (int i = 0; i < int'(BL); i++)
            exp_q.push_back(16'(i + (a[0] ? 1 : 0)));
    endtask

    task automatic clear_stats();
        ob_cnt = 0; done_cnt = 0; pop_cnt = 0; bad_pop = 0;
        cmd_log.delete();
    endtask

    task automatic wait_done(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check($sformatf("%s_done_seen", tag), 36'(ok), 36'(1));
    endtask

    task automatic burst(input logic [29:0] a, input logic [29:0] eaddr, input logic [5:0] ebl,
                         input int epops, input int full_cycles, input bit stall, input string tag);
        @(negedge clk);
        clear_stats();
        stall_rand = stall;
        cmd_full   = (full_cycles > 0);
        reads_en   = 1'b1;
        addr       = a;
        push_exp(a);
        @(negedge clk);
        check($sformatf("%s_busy", tag), 36'(busy), 36'(1));
        reads_en = 1'b0;
        addr     = 30'($urandom);
        for (int i = 0; i < full_cycles; i++) begin
            if (i > 0) @(negedge clk);
            check($sformatf("%s_cmd_held", tag), 36'(cmd_en), 36'(0));
        end
        cmd_full = 1'b0;
        wait_done(tag);
        @(negedge clk);
        check($sformatf("%s_done_1cyc", tag), 36'(done), 36'(0));
        check($sformatf("%s_idle", tag), 36'(busy), 36'(0));
        check($sformatf("%s_ncmd", tag), 36'(cmd_log.size()), 36'(1));
        if (cmd_log.size() != 0) begin
            check($sformatf("%s_addr", tag), 36'(cmd_log[0][29:0]), 36'(eaddr));
            check($sformatf("%s_bl", tag), 36'(cmd_log[0][35:30]), 36'(ebl));
        end
        check($sformatf("%s_ob_cnt", tag), 36'(ob_cnt), 36'(BL));
        check($sformatf("%s_pops", tag), 36'(pop_cnt), 36'(epops));
        check($sformatf("%s_ndone", tag), 36'(done_cnt), 36'(1));
        check($sformatf("%s_bad_pop", tag), 36'(bad_pop), 36'(0));
        check($sformatf("%s_sb_empty", tag), 36'(exp_q.size()), 36'(0));
        stall_rand = 1'b0;
    endtask

    initial begin
        int seen;
        rst = 1'b1; reads_en = 1'b0; addr = '0; cmd_full = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ob_data", 36'(ob_data), 36'(0));
        check("rst_ob_we", 36'(ob_we), 36'(0));
        check("rst_busy", 36'(busy), 36'(0));
        check("rst_done", 36'(done), 36'(0));
        check("rst_cmd_en", 36'(cmd_en), 36'(0));
        check("rst_cmd_bl", 36'(cmd_bl), 36'(0));
        check("rst_cmd_addr", 36'(cmd_byte_addr), 36'(0));
        check("rst_rd_en", 36'(rd_en), 36'(0));
        check("cmd_instr", 36'(cmd_instr), 36'(1));
        rst = 1'b0;

        // Idle with no request stays idle.
        repeat (4) @(negedge clk);
        check("idle_busy", 36'(busy), 36'(0));
        check("idle_ncmd", 36'(cmd_log.size()), 36'(0));

        burst(30'h100, 30'h200, 6'd7, 8, 0, 1'b0, "even");
        burst(30'h101, 30'h200, 6'd8, 9, 0, 1'b0, "odd");
        burst(30'h2A1, 30'h540, 6'd8, 9, 5, 1'b1, "bp");

        // Back-to-back: reads_en held, addr changed mid-burst.
        @(negedge clk);
        clear_stats();
        reads_en = 1'b1;
        addr     = 30'h300;
        push_exp(30'h300);
        push_exp(30'h455);
        @(negedge clk);
        addr = 30'h455;
        wait_done("b2b_1");
        check("b2b_no_overlap", 36'(cmd_log.size()), 36'(1));
        @(negedge clk);
        check("b2b_gap_idle", 36'(busy), 36'(0));
        @(negedge clk);
        check("b2b_restart", 36'(busy), 36'(1));
        reads_en = 1'b0;
        wait_done("b2b_2");
        @(negedge clk);
        check("b2b_ncmd", 36'(cmd_log.size()), 36'(2));
        if (cmd_log.size() == 2) begin
            check("b2b_addr1", 36'(cmd_log[0][29:0]), 36'(30'h600));
            check("b2b_bl1", 36'(cmd_log[0][35:30]), 36'(7));
            check("b2b_addr2", 36'(cmd_log[1][29:0]), 36'(30'h8A8));
            check("b2b_bl2", 36'(cmd_log[1][35:30]), 36'(8));
        end
        check("b2b_ob_cnt", 36'(ob_cnt), 36'(2 * BL));
        check("b2b_ndone", 36'(done_cnt), 36'(2));
        check("b2b_sb_empty", 36'(exp_q.size()), 36'(0));

        // Reset after the fifth element of a burst.
        @(negedge clk);
        clear_stats();
        stall_rand = 1'b1;
        reads_en   = 1'b1;
        addr       = 30'h40;
        push_exp(30'h40);
        @(negedge clk);
        reads_en = 1'b0;
        seen = 0;
        for (int i = 0; i < 400 && seen < 5; i++) begin
            if (ob_we) seen++;
            if (seen < 5) @(negedge clk);
        end
        check("mid_rst_reach5", 36'(seen), 36'(5));
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", 36'(busy), 36'(0));
        check("mid_rst_ob_we", 36'(ob_we), 36'(0));
        check("mid_rst_ob_data", 36'(ob_data), 36'(0));
        check("mid_rst_cmd_addr", 36'(cmd_byte_addr), 36'(0));
        rst = 1'b0;
        stall_rand = 1'b0;
        exp_q.delete();
        repeat (6) @(negedge clk);
        check("mid_rst_no_done", 36'(done_cnt), 36'(0));
        check("mid_rst_quiet", 36'(busy), 36'(0));

        burst(30'h41, 30'h80, 6'd8, 9, 0, 1'b1, "post_rst");
        burst(30'h3FFFFFFE, 30'h3FFFFFFC, 6'd7, 8, 0, 1'b0, "wrap");

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dma_rd_port.md
DMA_RD_PORT -- requirements
Module: dma_rd_port

Interface
REQ-001 Parameter BURST_LEN, default 16, is the number of 16-bit elements per burst; it SHALL be even and in the range 2..62.
REQ-002 clk  input  1  single clock; all state SHALL change on the rising edge.
REQ-003 rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-004 reads_en  input  1  level request from the engine: fetch one burst.
REQ-005 addr  input  30  start element address, in 16-bit units.
REQ-006 ob_data  output  16  element delivered to the engine.
REQ-007 ob_we  output  1  ob_data is valid this cycle.
REQ-008 busy  output  1  a burst is in progress.
REQ-009 done  output  1  one-cycle pulse when a burst completes.
REQ-010 cmd_en  output  1  memory command strobe.
REQ-011 cmd_instr  output  3  memory command; SHALL be 3'b001 (read).
REQ-012 cmd_bl  output  6  memory burst length in 32-bit words, minus 1.
REQ-013 cmd_byte_addr  output  30  memory byte address, 4-byte aligned.
REQ-014 cmd_full  input  1  memory command FIFO full.
REQ-015 rd_en  output  1  pop the memory read FIFO.
REQ-016 rd_data  input  32  head of the memory read FIFO.
REQ-017 rd_empty  input  1  memory read FIFO empty.

Function
REQ-018 States SHALL be IDLE, CMD, FETCH, EMIT_HI and DONE.
REQ-019 IDLE with reads_en=1: the block SHALL latch addr and go to CMD on the next edge.
REQ-020 IDLE with reads_en=0: the block SHALL stay in IDLE.
REQ-021 While the burst is active, cmd_byte_addr SHALL equal {addr[28:1],2'b00}, with the address wrapping modulo 2^30.
REQ-022 Word count N SHALL be BURST_LEN/2 when addr[0]=0, and BURST_LEN/2+1 when addr[0]=1.
REQ-023 cmd_bl SHALL equal N-1.
REQ-024 cmd_en SHALL be asserted for exactly one cycle per burst, in CMD, and only when cmd_full=0.
REQ-025 CMD SHALL hold while cmd_full=1, and go to FETCH after cmd_en is issued.
REQ-026 rd_en SHALL be combinational: 1 if and only if state=FETCH and rd_empty=0.
REQ-027 On a pop, rd_data SHALL be captured into a hold register.
REQ-028 On a pop, ob_data SHALL be set to rd_data[15:0] on the next edge.
REQ-029 On a pop, ob_we SHALL be 1 for that cycle, except on the first word of an odd-address burst, where the low half SHALL be dropped and ob_we SHALL be 0.
REQ-030 After a pop the state SHALL go to EMIT_HI.
REQ-031 EMIT_HI SHALL output the hold register bits [31:16] with ob_we=1, except on the last word of an odd-address burst, where the high half SHALL be dropped and ob_we SHALL be 0.
REQ-032 EMIT_HI SHALL go to FETCH if words remain, otherwise to DONE.
REQ-033 Output ordering SHALL be little-endian: the low half of each word before its high half.
REQ-034 Exactly BURST_LEN ob_we pulses SHALL occur per burst, with elements at consecutive addresses starting at the latched addr.
REQ-035 Peak throughput SHALL be one element per cycle.
REQ-036 FETCH with rd_empty=1 SHALL stall with ob_we=0; there is no timeout.
REQ-037 DONE SHALL pulse done=1 for one cycle, then go to IDLE.
REQ-038 If reads_en is still 1 in IDLE, the next burst SHALL start with no additional wait.
REQ-039 busy SHALL be 1 in every state except IDLE.
REQ-040 reads_en or addr changes after acceptance SHALL have no effect; a drop of reads_en mid-burst SHALL NOT abort the burst.
REQ-041 ob_data SHALL hold its last value when ob_we=0.

Reset
REQ-042 When rst=1 at an edge, the state SHALL go to IDLE and the counters and hold register SHALL clear.
REQ-043 After reset, ob_data, ob_we, busy, done and cmd_en SHALL be 0; cmd_bl and cmd_byte_addr SHALL be 0.
REQ-044 rst SHALL take priority over every other input, including a reset mid-burst.
REQ-045 The block SHALL NOT drain the memory FIFO on reset; the memory port is reset by the system at the same time.

Verification
REQ-046 Even address: addr=0x100, BURST_LEN=16, memory words 0x00010000+k*0x00020002 -> cmd_byte_addr=0x200, cmd_bl=7, 16 ob_we with ob_data 0..15 in order, one done pulse.
REQ-047 Odd address: addr=0x101 -> cmd_byte_addr=0x200, cmd_bl=8, 9 pops, exactly 16 ob_we, first ob_data = word0[31:16], last ob_data = word8[15:0].
REQ-048 Back-pressure: cmd_full=1 for 5 cycles -> cmd_en held off, then exactly one pulse; rd_empty toggled randomly -> same data order, ob_we count stays 16.
REQ-049 Back-to-back: reads_en held at 1, addr changed mid-burst -> second burst uses the addr present in IDLE, and the bursts do not overlap.
REQ-050 Reset mid-burst: rst after the 5th ob_we -> next cycle busy=0 and ob_we=0, no done pulse; a new request then completes normally.
REQ-051 Wrap: addr=0x3FFFFFFE -> cmd_byte_addr=0x3FFFFFFC (REQ-021, bit 29 dropped), 16 elements delivered.
